// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution datapath: activation
// encodings, fixed-point defaults and a width-generic saturation helper.
package conv_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RSVD  = 2'd3
  } act_e;

  localparam int LEAKY_SHIFT       = 3;
  localparam int DEFAULT_FRAC_BITS = 8;

  // Clamp a signed value to the range of a w-bit signed number; callers keep the low w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ROWS cascaded row-length shift lines; tap r is the pixel (r+1) rows above the
// one being shifted in. Storage is never cleared; the consumer ignores stale data.
module conv_line_buffer #(
  parameter int WIDTH      = 16,
  parameter int ROWS       = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]  taps
);

  logic [ROWS-1:0][WIDTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ROWS-1:0][DATA_WIDTH-1:0]            row_in;

  always_comb begin
    row_in    = '0;
    row_in[0] = din;
    for (int r = 1; r < ROWS; r++) row_in[r] = mem[r-1][WIDTH-1];
  end

  always_comb begin
    taps = '0;
    for (int r = 0; r < ROWS; r++) taps[r] = mem[r][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= {mem[r][WIDTH-2:0], row_in[r]};
    end
  end

endmodule

// File: rtl/conv2d_kxk_stream.sv
// Streaming KxK convolution over raster-order pixels with valid/ready flow
// control, saturating fixed-point MAC, selectable activation and end-of-frame marker.
module conv2d_kxk_stream import conv_pkg::*; #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int K          = 4,
  parameter int STRIDE     = 1,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   data_in,
  input  logic [K*K*DATA_WIDTH-1:0]      weights,
  input  logic signed [DATA_WIDTH-1:0]   bias,
  input  logic [1:0]                     act_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH-1:0]   data_out,
  output logic                           out_last
);

  localparam int PW       = 2 * DATA_WIDTH;
  localparam int ACC_W    = PW + $clog2(K * K) + 1;
  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int LAST_ROW = K - 1 + ((IMG_HEIGHT - K) / STRIDE) * STRIDE;
  localparam int LAST_COL = K - 1 + ((IMG_WIDTH - K) / STRIDE) * STRIDE;

  logic                               advance, accept;
  logic [CW-1:0]                      col;
  logic [RW-1:0]                      row;
  logic                               row_ok, col_ok, emit, is_last;
  logic [K-2:0][DATA_WIDTH-1:0]       lb_taps;
  logic [K-1:0][DATA_WIDTH-1:0]       col_in;
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win, nwin;
  logic [K*K-1:0][DATA_WIDTH-1:0]     w_arr;
  logic signed [ACC_W-1:0]            acc, shifted;
  logic signed [63:0]                 sat_full;
  logic signed [DATA_WIDTH-1:0]       sat, act_val;
  logic                               sat_unused;

  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept  = in_valid && advance;
  assign w_arr   = weights;

  conv_line_buffer #(
    .WIDTH     (IMG_WIDTH),
    .ROWS      (K - 1),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_line_buffer (
    .clk (clk),
    .en  (accept),
    .din (data_in),
    .taps(lb_taps)
  );

  // Window row 0 is the oldest row, column K-1 the newest pixel.
  always_comb begin
    col_in      = '0;
    col_in[K-1] = data_in;
    for (int r = 0; r < K - 1; r++) col_in[K-2-r] = lb_taps[r];
    nwin = win;
    for (int j = 0; j < K; j++) begin
      for (int i = 0; i < K - 1; i++) nwin[j][i] = win[j][i+1];
      nwin[j][K-1] = col_in[j];
    end
  end

  // MAC runs on the window as it will look after this accept: one-cycle latency.
  always_comb begin
    acc = ACC_W'(bias) <<< FRAC_BITS;
    for (int j = 0; j < K; j++) begin
      for (int i = 0; i < K; i++) begin
        acc = acc + ACC_W'(PW'($signed(w_arr[j*K+i])) * PW'($signed(nwin[j][i])));
      end
    end
  end

  assign shifted    = acc >>> FRAC_BITS;
  assign sat_full   = saturate(64'(shifted), DATA_WIDTH);
  assign sat        = sat_full[DATA_WIDTH-1:0];
  assign sat_unused = ^sat_full[63:DATA_WIDTH];

  always_comb begin
    act_val = sat;
    case (act_e'(act_mode))
      ACT_RELU:  if (sat[DATA_WIDTH-1]) act_val = '0;
      ACT_LEAKY: if (sat[DATA_WIDTH-1]) act_val = sat >>> LEAKY_SHIFT;
      default:   act_val = sat;
    endcase
  end

  assign row_ok  = (int'(row) >= K - 1) && (((int'(row) - (K - 1)) % STRIDE) == 0);
  assign col_ok  = (int'(col) >= K - 1) && (((int'(col) - (K - 1)) % STRIDE) == 0);
  assign emit    = row_ok && col_ok;
  assign is_last = (int'(row) == LAST_ROW) && (int'(col) == LAST_COL);

  always_ff @(posedge clk) begin
    if (accept) win <= nwin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_last  <= 1'b0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (accept) begin
        if (col == CW'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (advance) begin
        out_valid <= accept && emit;
        out_last  <= accept && emit && is_last;
        if (accept && emit) data_out <= act_val;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_kxk_stream.sv
// Bench for conv2d_kxk_stream: a K=3/S=1 and a K=2/S=2 instance on 6x6 frames,
// checked against a direct per-window arithmetic model.
module tb_conv2d_kxk_stream;

  typedef struct packed { logic [15:0] v; logic l; } res_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic signed [15:0] data_in = '0, bias = '0;
  logic [1:0] act_mode = '0;
  logic [9*16-1:0] wa = '0;
  logic [4*16-1:0] wb = '0;
  logic a_in_ready, a_out_valid, a_out_last, b_in_ready, b_out_valid, b_out_last;
  logic signed [15:0] a_data_out, b_data_out;

  int vectors = 0, errors = 0;
  longint pix[36];
  longint kw[9];
  longint bias_v = 0;
  int act_v = 0;
  res_t exp_q[$], got_a[$], got_b[$];

  always #5 clk = ~clk;

  conv2d_kxk_stream #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .K(3), .STRIDE(1),
                      .DATA_WIDTH(16), .FRAC_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .data_in(data_in), .weights(wa), .bias(bias), .act_mode(act_mode),
    .out_valid(a_out_valid), .out_ready(out_ready), .data_out(a_data_out),
    .out_last(a_out_last));

  conv2d_kxk_stream #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .K(2), .STRIDE(2),
                      .DATA_WIDTH(16), .FRAC_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .data_in(data_in), .weights(wb), .bias(bias), .act_mode(act_mode),
    .out_valid(b_out_valid), .out_ready(out_ready), .data_out(b_data_out),
    .out_last(b_out_last));

  // Record every completed output handshake just before the edge it happens on.
  always begin
    @(negedge clk); #4;
    if (rst_n && a_out_valid && out_ready) got_a.push_back('{a_data_out, a_out_last});
    if (rst_n && b_out_valid && out_ready) got_b.push_back('{b_data_out, b_out_last});
  end

  // Reference: walk the output positions of one 6x6 frame and convolve directly.
  task automatic ref_conv(input int k, input int s);
    for (int r = k - 1; r < 6; r += s) begin
      for (int c = k - 1; c < 6; c += s) begin
        longint acc, y;
        res_t e;
        acc = bias_v * 256;
        for (int j = 0; j < k; j++)
          for (int i = 0; i < k; i++)
            acc += pix[(r - k + 1 + j) * 6 + (c - k + 1 + i)] * kw[j * k + i];
        y = acc >>> 8;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (act_v == 1 && y < 0) y = 0;
        else if (act_v == 2 && y < 0) y = y >>> 3;
        e.v = 16'(y);
        e.l = (r + s >= 6) && (c + s >= 6);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic load_stim();
    for (int i = 0; i < 9; i++) wa[i*16 +: 16] = 16'(kw[i]);
    bias = 16'(bias_v);
    act_mode = 2'(act_v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_a.delete(); got_b.delete(); exp_q.delete();
  endtask

  // Feed npix pixels (frames repeat pix[]); optionally stall out_ready 5 cycles once.
  task automatic drive(input int npix, input bit rnd, input int stall_after, input bit drain);
    int idx = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [15:0] dq;
    logic lq;
    while (idx < npix && cyc < 4000) begin
      @(negedge clk);
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_in   = 16'(pix[idx % 36]);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_after >= 0 && !stalled && got_a.size() >= stall_after && a_out_valid) begin
        stalled = 1'b1; out_ready = 1'b0; dq = a_data_out; lq = a_out_last;
        for (int s = 0; s < 5; s++) begin
          #4; vectors++;
          if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_data_out !== dq || a_out_last !== lq) begin
            errors++;
            $display("FAIL stall cyc%0d: in_ready=%b valid=%b data=%h last=%b, want 0 1 %h %b",
                     s, a_in_ready, a_out_valid, a_data_out, a_out_last, dq, lq);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      #4;
      if (in_valid && a_in_ready) idx++;
      cyc++;
    end
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d of %0d pixels", idx, npix);
    end
    if (drain) begin
      repeat (4) begin @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; data_in = 16'($urandom); out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    vectors++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b want 0", a_out_valid); end
    vectors++; if (a_data_out !== 16'h0) begin errors++; $display("FAIL rst_a_data got %h want 0", a_data_out); end
    vectors++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL rst_a_last got %b want 0", a_out_last); end
    vectors++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready got %b want 1", a_in_ready); end
    vectors++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", b_out_valid); end
    vectors++; if (b_data_out !== 16'h0) begin errors++; $display("FAIL rst_b_data got %h want 0", b_data_out); end
    vectors++; if (b_out_last !== 1'b0) begin errors++; $display("FAIL rst_b_last got %b want 0", b_out_last); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_ones();
    do_reset();
    for (int i = 0; i < 36; i++) pix[i] = 256;
    for (int i = 0; i < 9; i++) kw[i] = 256;
    bias_v = 0; act_v = 0; load_stim(); ref_conv(3, 1);
    drive(36, 1'b0, -1, 1'b1);
    vectors++; if (got_a.size() !== 16) begin errors++; $display("FAIL ones_count got %0d want 16", got_a.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      vectors++;
      if (got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ones[%0d] got %0d/%b want %0d/%b", i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
      end
    end
  endtask

  task automatic test_stride();
    do_reset();
    for (int i = 0; i < 36; i++) pix[i] = 256 * i;
    for (int i = 0; i < 9; i++) kw[i] = (i == 0) ? 256 : 0;
    for (int i = 0; i < 4; i++) wb[i*16 +: 16] = 16'(kw[i]);
    bias_v = 0; act_v = 0; load_stim(); ref_conv(2, 2);
    drive(36, 1'b0, -1, 1'b1);
    vectors++; if (got_b.size() !== 9) begin errors++; $display("FAIL stride_count got %0d want 9", got_b.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      vectors++;
      if (got_b[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stride[%0d] got %0d/%b want %0d/%b", i, $signed(got_b[i].v), got_b[i].l, $signed(exp_q[i].v), exp_q[i].l);
      end
    end
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 2; p++) begin
      do_reset();
      for (int i = 0; i < 36; i++) pix[i] = 32767;
      for (int i = 0; i < 9; i++) kw[i] = (p == 0) ? 32767 : -32768;
      bias_v = 32767; act_v = 0; load_stim(); ref_conv(3, 1);
      drive(36, 1'b0, -1, 1'b1);
      vectors++; if (got_a.size() !== exp_q.size()) begin errors++; $display("FAIL sat%0d_count got %0d want %0d", p, got_a.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
        vectors++;
        if (got_a[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL sat%0d[%0d] got %0d/%b want %0d/%b", p, i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
        end
      end
    end
  endtask

  task automatic test_activation();
    for (int m = 1; m < 4; m++) begin
      do_reset();
      for (int i = 0; i < 36; i++) pix[i] = 256;
      for (int i = 0; i < 9; i++) kw[i] = -256;
      bias_v = 0; act_v = m; load_stim(); ref_conv(3, 1);
      drive(36, 1'b0, -1, 1'b1);
      vectors++; if (got_a.size() !== exp_q.size()) begin errors++; $display("FAIL act%0d_count got %0d want %0d", m, got_a.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
        vectors++;
        if (got_a[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL act%0d[%0d] got %0d/%b want %0d/%b", m, i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 36; i++) pix[i] = 256;
    for (int i = 0; i < 9; i++) kw[i] = 256;
    bias_v = 0; act_v = 0; load_stim(); ref_conv(3, 1);
    drive(36, 1'b0, 6, 1'b1);
    vectors++; if (got_a.size() !== 16) begin errors++; $display("FAIL bp_count got %0d want 16", got_a.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      vectors++;
      if (got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp[%0d] got %0d/%b want %0d/%b", i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lasts = 0;
    do_reset();
    for (int i = 0; i < 36; i++) pix[i] = 256;
    for (int i = 0; i < 9; i++) kw[i] = 256;
    bias_v = 0; act_v = 0; load_stim();
    drive(20, 1'b0, -1, 1'b0);
    do_reset();
    ref_conv(3, 1); ref_conv(3, 1);
    drive(72, 1'b0, -1, 1'b1);
    vectors++; if (got_a.size() !== 32) begin errors++; $display("FAIL midrst_count got %0d want 32", got_a.size()); end
    foreach (got_a[i]) if (got_a[i].l) lasts++;
    vectors++; if (lasts !== 2) begin errors++; $display("FAIL midrst_lasts got %0d want 2", lasts); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      vectors++;
      if (got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst[%0d] got %0d/%b want %0d/%b", i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < 36; i++) pix[i] = longint'($urandom_range(0, 16000)) - 8000;
      for (int i = 0; i < 9; i++) kw[i] = longint'($urandom_range(0, 1200)) - 600;
      bias_v = longint'($urandom_range(0, 8000)) - 4000;
      act_v = int'($urandom_range(0, 3));
      load_stim(); ref_conv(3, 1); ref_conv(3, 1);
      drive(72, 1'b1, -1, 1'b1);
      vectors++; if (got_a.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, got_a.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
        vectors++;
        if (got_a[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd%0d[%0d] got %0d/%b want %0d/%b", it, i, $signed(got_a[i].v), got_a[i].l, $signed(exp_q[i].v), exp_q[i].l);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_stride();
    test_saturation();
    test_activation();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_kxk_stream.md
Name: conv2d_kxk_stream

Overview:
Streaming 2-D convolution over a raster-order, single-channel image, generalised from the fixed 4x4 layer. Kernel size, stride, image dimensions and Q-format are parameters. The block adds valid/ready backpressure, frame wrap with an end-of-frame marker, saturating arithmetic and a selectable output activation. It sits between the pixel source (DMA or previous layer) and the next layer in the generator/discriminator datapath.

Parameters:
IMG_WIDTH, 16, pixels per row (>= K)
IMG_HEIGHT, 16, rows per frame (>= K)
K, 4, kernel edge; legal range 2..5
STRIDE, 1, output stride in both axes; 1 or 2
DATA_WIDTH, 16, signed fixed-point width of pixels, weights, bias and output
FRAC_BITS, 8, fractional bits; Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  pixel present
in_ready  out  1  block accepts the pixel
data_in  in  DATA_WIDTH  signed pixel, raster order
weights  in  K*K*DATA_WIDTH  flattened; slice j*K+i is weight for row j, col i (row 0 = oldest row, col 0 = leftmost); static during a frame
bias  in  DATA_WIDTH  signed, same Q-format
act_mode  in  2  0 = none, 1 = ReLU, 2 = leaky (neg >>> 3), 3 = reserved (treated as none); sampled with each output
out_valid  out  1  result present
out_ready  in  1  downstream accepts the result
data_out  out  DATA_WIDTH  signed result
out_last  out  1  qualifies the final output of a frame

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, data_out=0, out_last=0, col/row counters=0, window-valid=0. Line buffers and window are not cleared; stale contents are never emitted.
- advance = !out_valid || out_ready; in_ready = advance (combinational). Accept = in_valid && in_ready.
- On accept: the pixel shifts into the K-1 line buffers and the KxK window, and col/row advance. col wraps at IMG_WIDTH-1. row increments on col wrap and wraps to 0 after (IMG_WIDTH-1, IMG_HEIGHT-1); the next pixel starts a new frame. There is no dead cycle between frames.
- Window is emittable iff row >= K-1, col >= K-1, (row-(K-1)) % STRIDE == 0 and (col-(K-1)) % STRIDE == 0, evaluated on the accepted pixel's coordinates. The horizontal window at col K-1..W-1 never spans a row boundary.
- Latency: result of the window completed by the accept at edge E0 appears with out_valid=1 after E0, i.e. 1 cycle.
- At any advance edge: out_valid <= window-valid-from-this-accept, data_out and out_last are updated accordingly. At a non-advance edge the output holds and no input is accepted.
- Outputs per frame: ((IMG_WIDTH-K)/STRIDE+1)*((IMG_HEIGHT-K)/STRIDE+1). out_last=1 only on the output whose window ends at the last emittable position.
- Arithmetic:
  - Full-precision products of 2*DATA_WIDTH bits.
  - Accumulator of 2*DATA_WIDTH+clog2(K*K)+1 bits; bias added as bias <<< FRAC_BITS.
  - Result = acc >>> FRAC_BITS (arithmetic shift, floor), then saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Activation is applied after saturation.
- in_valid low: state holds; a pending output still drains when out_ready is high.
- Reset mid-frame drops any pending output; the next accepted pixel is (0,0).

Decomposition:
- Shared package conv_pkg: ACT_NONE/ACT_RELU/ACT_LEAKY encodings, LEAKY_SHIFT=3, saturate function (width-parametrised), default FRAC_BITS.
- Sub-module conv_line_buffer (K-1 rows x IMG_WIDTH shift storage with shift-enable, exposing the tail of each row) instantiated once.
- MAC loop, activation and handshake stay in the top.

Test Plan:
1. W=H=6, K=3, S=1, all pixels 256 (1.0), all weights 256, bias 0, act 0 -> 16 outputs each 2304, out_last only on the 16th.
2. W=H=6, K=2, S=2, pixel value = 256*(row*6+col), weight (0,0)=256 others 0 -> 9 outputs equal to 256*{0,2,4,12,14,16,24,26,28}, out_last on the 9th.
3. K=3, pixels 0x7FFF, weights 0x7FFF, bias 0x7FFF -> every output 32767; with weights 0x8000 -> -32768.
4. Case-1 image, weights -256: act 1 -> outputs 0; act 2 -> outputs -288; act 3 -> outputs -2304.
5. Case 1 with out_ready held low for 5 cycles mid-stream -> in_ready low in the same cycles, data_out and out_last stable, no output lost or duplicated (16 total).
6. Reset asserted after 20 accepted pixels, then 2 back-to-back full frames -> exactly 16+16 outputs, out_last twice, values as case 1.
